// File: rtl/mux_arb.sv
// N-channel valid/ready multiplexer with a registered output stage, round-robin or manual select.
// Define MUX_ARB_FIXED_PRIO_EN to make arbitrated mode fixed-priority (lowest valid index wins).
module mux_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] words [CHANNELS];

    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [SEL_W-1:0] out_sel_reg, out_sel_next;
    logic             out_valid_reg, out_valid_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;

    logic             accept;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_word;
    logic             load_en;

    // Reset gates the handshake so no producer sees a take while the stage is being cleared.
    assign load_en = accept && grant_valid && !reset;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign words[gi]    = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = load_en && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        accept      = !out_valid_reg || out_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ((int'(sel) == i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            // Walk the search order backwards so the earliest candidate overwrites later ones.
            for (int k = CHANNELS; k >= 1; k--) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                if (in_valid[k-1]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(k-1);
                end
`else
                if (in_valid[(int'(ptr_reg) + k) % CHANNELS]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'((int'(ptr_reg) + k) % CHANNELS);
                end
`endif
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_word = words[i];
            end
        end
    end

    always_comb begin
        out_data_next  = out_data_reg;
        out_sel_next   = out_sel_reg;
        out_valid_next = out_valid_reg;
        ptr_next       = ptr_reg;
        if (accept) begin
            if (grant_valid) begin
                out_data_next  = grant_word;
                out_sel_next   = grant_idx;
                out_valid_next = 1'b1;
                ptr_next       = grant_idx;
            end else begin
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= SEL_W'(CHANNELS-1);
        end else begin
            out_data_reg  <= out_data_next;
            out_sel_reg   <= out_sel_next;
            out_valid_reg <= out_valid_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: directed test-plan steps, then randomized traffic against a model.
// A second 5-channel instance covers out-of-range manual select values.
module tb_mux_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic           clock;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_valid;
    logic           out_ready;

    logic [39:0]    in_data5;
    logic [4:0]     in_valid5;
    logic [4:0]     in_ready5;
    logic           mode5;
    logic [2:0]     sel5;
    logic [7:0]     out_data5;
    logic [2:0]     out_sel5;
    logic           out_valid5;
    logic           out_ready5;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the output register should hold and who was granted last.
    logic           m_valid;
    logic [W-1:0]   m_data;
    int             m_sel;
    int             m_last;

    mux_arb #(.WIDTH(W), .CHANNELS(N)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_arb #(.WIDTH(8), .CHANNELS(5)) dut5 (
        .clock(clock), .reset(reset), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
        .out_sel(out_sel5), .out_valid(out_valid5), .out_ready(out_ready5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int c);
        logic [N*W-1:0] d;
        d = in_data;
        return d[c*W +: W];
    endfunction

    // Which channel the rules say wins this cycle, or -1 for none.
    function automatic int model_grant();
        if (mode) begin
            return in_valid[sel] ? int'(sel) : -1;
        end
`ifdef MUX_ARB_FIXED_PRIO_EN
        for (int c = 0; c < N; c++) if (in_valid[c]) return c;
`else
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (m_last + off) % N;
            if (in_valid[c]) return c;
        end
`endif
        return -1;
    endfunction

    // One clock: check in_ready before the edge, update the model, check outputs after.
    task automatic step();
        int  g;
        bit  acc;
        logic [N-1:0] exp_rdy;
        #1;
        g   = model_grant();
        acc = !m_valid || out_ready;
        exp_rdy = '0;
        if (!reset && acc && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clock);
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = N-1;
        end else if (acc) begin
            if (g >= 0) begin
                m_valid = 1'b1; m_data = word_of(g); m_sel = g; m_last = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clock);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_sel", 64'(out_sel), 64'(m_sel));
    endtask

    initial begin
        int rr_exp [5];
        int man_sel [4];
        int man_exp [4];
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = N-1;
        reset = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1;
        in_valid = 4'b1111;
        in_data = {32'd400, 32'd300, 32'd200, 32'd100};
        in_data5 = {8'd55, 8'd44, 8'd33, 8'd22, 8'd11};
        in_valid5 = '0; mode5 = 1'b1; sel5 = '0; out_ready5 = 1'b1;
        @(negedge clock);

        // Reset with everything valid: nothing handed out.
        step();
        step();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);

        // Round-robin over four always-valid channels.
        reset = 1'b0;
`ifdef MUX_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_sel", 64'(out_sel), 64'(rr_exp[i]));
            chk("rr_data", 64'(out_data), 64'((rr_exp[i] + 1) * 100));
        end

        // Manual mode follows sel immediately.
        mode = 1'b1; in_valid = 4'b0011;
        man_sel = '{0, 0, 1, 0};
        man_exp = '{100, 100, 200, 100};
        for (int i = 0; i < 4; i++) begin
            sel = 2'(man_sel[i]);
            step();
            chk("manual_data", 64'(out_data), 64'(man_exp[i]));
        end
        // Selected channel idle while others are valid: output drains.
        sel = 2'd2;
        step();
        chk("manual_idle_ready", 64'(in_ready), 64'd0);
        chk("manual_idle_valid", 64'(out_valid), 64'd0);

        // Back-pressure holds the word and blocks all producers.
        mode = 1'b0; in_valid = 4'b0001; out_ready = 1'b1;
        step();
        chk("bp_first", 64'(out_data), 64'd100);
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 64'(in_ready), 64'd0);
            step();
            chk("bp_hold", 64'(out_data), 64'd100);
        end
        out_ready = 1'b1; in_valid = 4'b0010;
        step();
        chk("bp_nobubble_valid", 64'(out_valid), 64'd1);
        chk("bp_nobubble_data", 64'(out_data), 64'd200);

        // Sparse requests, pointer wrap, then drain with data held.
        in_valid = 4'b1000;
        step();
        chk("sparse_sel3", 64'(out_sel), 64'd3);
        in_valid = 4'b0010;
        step();
        chk("sparse_sel1", 64'(out_sel), 64'd1);
        in_valid = 4'b0000;
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_hold", 64'(out_data), 64'd200);

        // Reset while a word is stalled.
        in_valid = 4'b0100;
        step();
        out_ready = 1'b0; reset = 1'b1; in_valid = 4'b1111;
        step();
        chk("midreset_valid", 64'(out_valid), 64'd0);
        reset = 1'b0; out_ready = 1'b1;
        step();
        chk("midreset_restart", 64'(out_sel), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            mode      = ($urandom_range(0, 3) == 0);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
            step();
        end
        reset = 1'b0;
        step();

        // Five-channel instance: select values past the last channel never grant.
        in_valid5 = 5'b11111; sel5 = 3'd2;
        #1;
        chk("sel5_ready2", 64'(in_ready5), 64'b00100);
        @(posedge clock); @(negedge clock);
        chk("sel5_valid2", 64'(out_valid5), 64'd1);
        chk("sel5_data2", 64'(out_data5), 64'd33);
        chk("sel5_sel2", 64'(out_sel5), 64'd2);
        for (int s = 5; s <= 7; s++) begin
            sel5 = 3'(s);
            #1;
            chk("sel5_oor_ready", 64'(in_ready5), 64'd0);
            @(posedge clock); @(negedge clock);
            chk("sel5_oor_valid", 64'(out_valid5), 64'd0);
            chk("sel5_oor_hold", 64'(out_data5), 64'd33);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
